fetch_ctrl: RTL

//  Sequences instruction fetch: owns the PC and drives a multi-cycle instruction-memory req/ack port.

---
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives a multi-cycle imem req/ack port, optional FETCH_PERF_CNT_EN counters.
// Latency: captured word appears on instr_out the cycle after imem_ack; sustains 1 word/cycle with a 1-cycle ack.
// Backpressure: a new request is issued only while the output slot is empty or being accepted (instr_ready).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        instr_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        timeout_err,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_OUT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [7:0]  wait_cnt;
  logic        slot_free;
  logic        req_wait;
  logic [31:0] target_al;
  logic        target_mis;

  // The slot counts as free when it is empty or being consumed this cycle,
  // which lets back-to-back fetches overlap with downstream acceptance.
  assign slot_free  = !instr_valid || instr_ready;
  assign imem_req   = (state == DRAIN) || ((state == REQ) && slot_free);
  assign imem_addr  = imem_req ? ((state == DRAIN) ? drain_addr : pc) : 32'h0;
  assign req_wait   = imem_req && !imem_ack;
  assign target_al  = {branch_target[31:2], 2'b00};
  assign target_mis = (branch_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drain_addr   <= 32'h0;
      wait_cnt     <= 8'd0;
      instr_valid  <= 1'b0;
      instr_out    <= 32'h0;
      pc_out       <= 32'h0;
      flush_out    <= 1'b0;
      timeout_err  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      flush_out <= 1'b0;

      // Outstanding-request watchdog; the request itself is never abandoned.
      if (req_wait) begin
        if (wait_cnt != MAX_W)
          wait_cnt <= wait_cnt + 8'd1;
        if ((wait_cnt == MAX_W - 8'd1) || (wait_cnt == MAX_W))
          timeout_err <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end

      if (state == IDLE) begin
        state <= REQ;
      end else if (branch_taken) begin
        pc          <= target_al;
        instr_valid <= 1'b0;
        flush_out   <= 1'b1;
        if (target_mis)
          misalign_err <= 1'b1;
        unique case (state)
          REQ: begin
            // An unanswered request must still be retired before redirecting.
            if (req_wait) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end else begin
              state <= REQ;
            end
          end
          DRAIN:   state <= imem_ack ? REQ : DRAIN;
          default: state <= REQ;
        endcase
      end else begin
        unique case (state)
          REQ: begin
            if (imem_req && imem_ack) begin
              instr_out   <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
            end else if (!imem_req) begin
              state <= WAIT_OUT;
            end else if (instr_valid && instr_ready) begin
              instr_valid <= 1'b0;
            end
          end
          WAIT_OUT: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              state       <= REQ;
            end
          end
          DRAIN: begin
            if (imem_ack)
              state <= REQ;
          end
          default: state <= REQ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic capture;
  assign capture = (state == REQ) && imem_req && imem_ack && !branch_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (capture)
        perf_fetched <= perf_fetched + 32'd1;
      if (req_wait || (instr_valid && !instr_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
